// File: rtl/pe64_grant_scheduler_if.sv
// Grant handshake bundle between the scheduler (master) and the grant consumer (slave).
interface pe64_grant_scheduler_if #(
  parameter int unsigned IdxW = 6
) ();
  logic            grant_valid;
  logic [IdxW-1:0] grant_idx;
  logic            grant_ready;

  modport master (
    output grant_valid,
    output grant_idx,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_idx,
    output grant_ready
  );
endinterface

// File: rtl/pe64_grant_scheduler.sv
// 64-request pending register with a 4x16 two-level priority encode and a valid/ready grant offer.
// Optional macro PE_SCHED_MASK_EN adds req_mask_i; masked bits stay pending but are never offered.
module pe64_grant_scheduler #(
  parameter int unsigned Width = 64,
  parameter int unsigned IdxW  = 6,
  parameter int unsigned CntW  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [Width-1:0]      req_set_i,
  input  logic [Width-1:0]      req_clr_i,
`ifdef PE_SCHED_MASK_EN
  input  logic [Width-1:0]      req_mask_i,
`endif
  pe64_grant_scheduler_if.master grant_if,
  output logic [Width-1:0]      pending_o,
  output logic                  empty_o,
  output logic [CntW-1:0]       grant_cnt_o
);

  localparam int unsigned NumRows = Width / 4;

  if (Width != 64) begin : gen_width_err
    $error("pe64_grant_scheduler: only Width == 64 is supported");
  end
  if (IdxW != $clog2(Width)) begin : gen_idxw_err
    $error("pe64_grant_scheduler: IdxW must equal log2(Width)");
  end

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] pending_q, pending_d;
  logic [IdxW-1:0]  grant_idx_q, grant_idx_d;
  logic [CntW-1:0]  grant_cnt_q, grant_cnt_d;
  logic             grant_valid_q, grant_valid_d;

  logic [Width-1:0]   eligible;
  logic [NumRows-1:0] row_any;
  logic [3:0]         row_sel;
  logic [3:0]         row_bits;
  logic [1:0]         col_sel;
  logic [IdxW-1:0]    enc_idx;
  logic               accept;
  logic [Width-1:0]   accept_vec;

`ifdef PE_SCHED_MASK_EN
  assign eligible = pending_q & ~req_mask_i;
`else
  assign eligible = pending_q;
`endif

  // Two-level encode: highest non-empty row, then highest set column inside it.
  always_comb begin
    row_any = '0;
    for (int r = 0; r < int'(NumRows); r++) begin
      row_any[r] = |eligible[4*r +: 4];
    end
    row_sel = '0;
    for (int r = 0; r < int'(NumRows); r++) begin
      if (row_any[r]) row_sel = 4'(r);
    end
    row_bits = eligible[{row_sel, 2'b00} +: 4];
    col_sel  = '0;
    for (int c = 0; c < 4; c++) begin
      if (row_bits[c]) col_sel = 2'(c);
    end
    enc_idx = {row_sel, col_sel};
  end

  assign accept     = (state_q == StOffer) && grant_if.grant_ready;
  assign accept_vec = accept ? (Width'(1) << grant_idx_q) : '0;

  // Clear beats set beats acceptance; a set coinciding with its own acceptance is kept.
  assign pending_d = ((pending_q & ~accept_vec) | req_set_i) & ~req_clr_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      grant_idx_q   <= '0;
      grant_cnt_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_idx_q   <= grant_idx_d;
      grant_cnt_q   <= grant_cnt_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|eligible) state_d = StOffer;
      StOffer: if (grant_if.grant_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values; grant_idx is frozen for the whole offer.
  always_comb begin
    grant_idx_d   = grant_idx_q;
    grant_cnt_d   = grant_cnt_q;
    grant_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          grant_idx_d   = enc_idx;
          grant_valid_d = 1'b1;
        end
      end
      StOffer: begin
        if (grant_if.grant_ready) begin
          grant_cnt_d = grant_cnt_q + CntW'(1);
        end else begin
          grant_valid_d = 1'b1;
        end
      end
      default: grant_valid_d = 1'b0;
    endcase
  end

  assign grant_if.grant_valid = grant_valid_q;
  assign grant_if.grant_idx   = grant_idx_q;
  assign pending_o            = pending_q;
  assign empty_o              = (pending_q == '0);
  assign grant_cnt_o          = grant_cnt_q;

endmodule

// File: tb/tb_pe64_grant_scheduler.sv
// Directed, table-driven bench for pe64_grant_scheduler plus reset and mask corner sequences.
module tb_pe64_grant_scheduler;

  logic        clk;
  logic        rst;
  logic [63:0] req_set;
  logic [63:0] req_clr;
`ifdef PE_SCHED_MASK_EN
  logic [63:0] req_mask;
`endif
  logic [63:0] pending;
  logic        empty;
  logic [15:0] grant_cnt;

  pe64_grant_scheduler_if #(.IdxW(6)) gif ();

  pe64_grant_scheduler #(
    .Width(64),
    .IdxW (6),
    .CntW (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_set_i  (req_set),
    .req_clr_i  (req_clr),
`ifdef PE_SCHED_MASK_EN
    .req_mask_i (req_mask),
`endif
    .grant_if   (gif),
    .pending_o  (pending),
    .empty_o    (empty),
    .grant_cnt_o(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] set;
    logic [63:0] clr;
    logic        ready;
    logic        valid;
    logic [5:0]  idx;
    logic [63:0] pend;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fails;

  function automatic logic [63:0] b(input int n);
    b = 64'd1 << n;
  endfunction

  function automatic vec_t mk(input logic [63:0] set, input logic [63:0] clr, input logic ready,
                              input logic valid, input logic [5:0] idx, input logic [63:0] pend,
                              input logic [15:0] cnt);
    vec_t v;
    v.set = set; v.clr = clr; v.ready = ready;
    v.valid = valid; v.idx = idx; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic valid, input logic [5:0] idx,
                           input logic [63:0] pend, input logic [15:0] cnt);
    chk({tag, ".valid"}, 64'(gif.grant_valid), 64'(valid));
    chk({tag, ".pending"}, pending, pend);
    chk({tag, ".empty"}, 64'(empty), 64'(pend == 64'd0));
    chk({tag, ".cnt"}, 64'(grant_cnt), 64'(cnt));
    if (valid) chk({tag, ".idx"}, 64'(gif.grant_idx), 64'(idx));
  endtask

  task automatic step(input logic [63:0] set, input logic [63:0] clr, input logic ready);
    @(negedge clk);
    req_set         = set;
    req_clr         = clr;
    gif.grant_ready = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    rst             = 1'b1;
    req_set         = '0;
    req_clr         = '0;
    gif.grant_ready = 1'b0;
`ifdef PE_SCHED_MASK_EN
    req_mask        = '0;
`endif
    #12;
    chk("reset.idx", 64'(gif.grant_idx), 64'd0);
    check_all("reset", 1'b0, 6'd0, 64'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 20; i++) begin
      step('0, '0, 1'b0);
      check_all($sformatf("idle%0d", i), 1'b0, 6'd0, 64'd0, 16'd0);
    end

    // set, clr, ready -> valid, idx, pending, cnt seen after the edge.
    vecs.push_back(mk(b(37), '0, 1, 0, 0, b(37), 0));
    vecs.push_back(mk('0, '0, 1, 1, 37, b(37), 0));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 1));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(b(0) | b(5) | b(62), '0, 1, 0, 0, b(0) | b(5) | b(62), 1));
    vecs.push_back(mk('0, '0, 1, 1, 62, b(0) | b(5) | b(62), 1));
    vecs.push_back(mk('0, '0, 1, 0, 0, b(0) | b(5), 2));
    vecs.push_back(mk('0, '0, 1, 1, 5, b(0) | b(5), 2));
    vecs.push_back(mk('0, '0, 1, 0, 0, b(0), 3));
    vecs.push_back(mk('0, '0, 1, 1, 0, b(0), 3));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 4));
    // Stalled offer of 5: a higher request and a withdraw must not disturb it.
    vecs.push_back(mk(b(5), '0, 0, 0, 0, b(5), 4));
    vecs.push_back(mk('0, '0, 0, 1, 5, b(5), 4));
    vecs.push_back(mk(b(60), '0, 0, 1, 5, b(5) | b(60), 4));
    vecs.push_back(mk('0, b(5), 0, 1, 5, b(60), 4));
    vecs.push_back(mk('0, '0, 0, 1, 5, b(60), 4));
    vecs.push_back(mk('0, '0, 1, 0, 0, b(60), 5));
    vecs.push_back(mk('0, '0, 1, 1, 60, b(60), 5));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 6));
    // Re-request in the acceptance cycle, then set+clr on the same bit.
    vecs.push_back(mk(b(12), '0, 1, 0, 0, b(12), 6));
    vecs.push_back(mk('0, '0, 1, 1, 12, b(12), 6));
    vecs.push_back(mk(b(12), '0, 1, 0, 0, b(12), 7));
    vecs.push_back(mk('0, '0, 1, 1, 12, b(12), 7));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 8));
    vecs.push_back(mk(b(9), b(9), 1, 0, 0, 0, 8));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 8));
    // Same-row column priority and cross-row ordering.
    vecs.push_back(mk(b(3) | b(13) | b(14), '0, 1, 0, 0, b(3) | b(13) | b(14), 8));
    vecs.push_back(mk('0, '0, 1, 1, 14, b(3) | b(13) | b(14), 8));
    vecs.push_back(mk('0, '0, 1, 0, 0, b(3) | b(13), 9));
    vecs.push_back(mk('0, '0, 1, 1, 13, b(3) | b(13), 9));
    vecs.push_back(mk('0, '0, 1, 0, 0, b(3), 10));
    vecs.push_back(mk('0, '0, 1, 1, 3, b(3), 10));
    vecs.push_back(mk('0, '0, 1, 0, 0, 0, 11));

    foreach (vecs[k]) begin
      step(vecs[k].set, vecs[k].clr, vecs[k].ready);
      check_all($sformatf("vec%0d", k), vecs[k].valid, vecs[k].idx, vecs[k].pend, vecs[k].cnt);
    end

    // Asynchronous reset in the middle of an offer of 40.
    step(b(40), '0, 1'b0);
    step('0, '0, 1'b0);
    check_all("pre_rst", 1'b1, 6'd40, b(40), 16'd11);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.idx", 64'(gif.grant_idx), 64'd0);
    check_all("async_rst", 1'b0, 6'd0, 64'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step('0, '0, 1'b1);
    check_all("post_rst", 1'b0, 6'd0, 64'd0, 16'd0);

`ifdef PE_SCHED_MASK_EN
    // Masked 50 stays pending but only 3 is offered until the mask lifts.
    req_mask = b(50);
    step(b(50) | b(3), '0, 1'b1);
    check_all("mask0", 1'b0, 6'd0, b(50) | b(3), 16'd0);
    step('0, '0, 1'b1);
    check_all("mask1", 1'b1, 6'd3, b(50) | b(3), 16'd0);
    step('0, '0, 1'b1);
    check_all("mask2", 1'b0, 6'd0, b(50), 16'd1);
    step('0, '0, 1'b1);
    check_all("mask3", 1'b0, 6'd0, b(50), 16'd1);
    req_mask = '0;
    step('0, '0, 1'b1);
    check_all("mask4", 1'b1, 6'd50, b(50), 16'd1);
    step('0, '0, 1'b1);
    check_all("mask5", 1'b0, 6'd0, 64'd0, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pe64_grant_scheduler.md
Name: pe64_grant_scheduler

Overview:
- Sequential front end for the 64-bit two-level priority encoder. It accumulates 64 single-cycle request pulses into a pending register and runs the registered vector through the 4x16 row/column encode, highest index first.
- It offers the winning index on a valid/ready handshake and clears the serviced pending bit on acceptance.
- It sits between the request sources (interrupt lines, queue-not-empty flags) and the grant consumer.

Parameters:
- WIDTH, 64, request vector width; only 64 is supported, and any other value is an elaboration error.
- IDX_W, 6, grant index width; must equal log2(WIDTH).
- CNT_W, 16, width of the accepted-grant statistics counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_set  in  64  one-cycle pulses; bit i=1 sets pending[i].
- req_clr  in  64  one-cycle pulses; bit i=1 clears pending[i] (withdraw).
- grant_valid  out  1  an index is being offered.
- grant_idx  out  6  offered index; bits [5:2] are the row (group of 4), bits [1:0] are the column.
- grant_ready  in  1  the consumer accepts the offer when high with grant_valid.
- pending  out  64  current pending register.
- empty  out  1  high when pending == 0.
- grant_cnt  out  CNT_W  count of accepted grants; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - pending=0, grant_valid=0, grant_idx=0, grant_cnt=0, state=IDLE, empty=1.
- Pending update, per bit each cycle, in decreasing priority:
  - req_clr[i] forces 0.
  - Otherwise req_set[i] forces 1.
  - Otherwise, an accepted handshake with grant_idx==i forces 0.
  - Otherwise the bit holds.
  - A set arriving in the same cycle as its own grant acceptance is retained as a new request.
- Encode:
  - Combinational over the registered pending vector (eligible vector; see the optional feature).
  - Row OR per group of 4 bits, highest non-zero row wins; within that row, the highest set bit wins.
  - Result is the 6-bit index {row,col}. Bit 63 has highest priority, bit 0 lowest.
- FSM states are IDLE and OFFER.
  - IDLE: if eligible != 0, register the encoder index into grant_idx, set grant_valid=1, go to OFFER. Otherwise stay; grant_valid=0.
  - OFFER: grant_valid=1. grant_idx is held stable regardless of new higher-priority requests or req_clr of the offered bit.
  - OFFER, grant_ready=1: clear pending[grant_idx] (no-op if it was already withdrawn), increment grant_cnt, go to IDLE, grant_valid=0 next cycle.
  - OFFER, grant_ready=0: stay in OFFER.
- Latency and throughput:
  - A req_set pulse at edge t is visible in pending after edge t; grant_valid rises after edge t+1 (2 cycles).
  - Maximum throughput is one grant per 2 cycles, because the IDLE bubble guarantees the encoder sees the post-clear vector.
- Outputs are registered except empty, which is combinational from pending.
- grant_cnt wraps from 2^CNT_W-1 to 0 silently.
- Reset asserted mid-offer: everything returns to reset values immediately. The offer is lost and no count is recorded.
- grant_ready while grant_valid=0 is ignored.

Optional Feature:
- PE_SCHED_MASK_EN
  - Defined: adds input port req_mask [63:0]. Eligible vector = pending & ~req_mask.
  - Masked bits stay pending and are reported in pending/empty, but are never offered.
  - Masking the offered bit during OFFER does not revoke the offer.
- Undefined: no req_mask port; eligible = pending.

Test Plan:
- Reset then idle, no requests -> grant_valid=0, empty=1, pending=0, grant_cnt=0 for 20 cycles.
- Single req_set bit 37 at cycle 0, grant_ready=1 -> grant_valid high at cycle 2 with grant_idx=37. It drops at cycle 3, pending=0, grant_cnt=1.
- req_set with bits 0, 5, 62 together, grant_ready=1 -> grants in order 62, 5, 0, on cycles 2, 4, 6. After that, empty=1 and grant_cnt=3.
- Offer idx 5 with grant_ready=0 for 4 cycles; inject req_set bit 60 and req_clr bit 5 during the offer -> grant_idx stays 5. On acceptance grant_cnt increments and pending[5] stays 0. The next offer is 60.
- In the acceptance cycle of idx 12, also pulse req_set bit 12 -> pending[12] remains 1 and idx 12 is re-offered 2 cycles later. Also: req_set and req_clr on bit 9 in the same cycle -> pending[9]=0.
- rst asserted asynchronously mid-OFFER (idx 40) -> grant_valid, pending and grant_cnt are 0 immediately, without waiting for a clock edge. With PE_SCHED_MASK_EN, requests 50 and 3 with req_mask bit 50 set -> only 3 is offered, pending[50] stays 1.
